// File: rtl/game_pkg.sv
// Shared types and helpers for the per-frame game controller and its tick generator.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    SPRITE    = 3'd2,
    PHYSICS   = 3'd3,
    SCROLL    = 3'd4,
    WAIT_TICK = 3'd5
  } state_e;

  localparam logic [1:0] SRC_BG     = 2'd0;
  localparam logic [1:0] SRC_OBS    = 2'd1;
  localparam logic [1:0] SRC_PLAYER = 2'd2;

  // Bits needed to hold values 0..n-1 (0 for n <= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running frame-tick counter 0..DIV-1; wrap_o pulses on the last count while enabled.
module tick_gen
  import game_pkg::*;
#(
  parameter int DIV = 833333
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic wrap_o
);

  localparam int CW = (DIV > 1) ? clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign wrap_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame game controller: clear, draw sprites (player last), physics, scroll, wait for tick.
// Emits one registered pixel per clock; dbg_state mirrors the FSM state.
module frame_sequencer
  import game_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCR_W    = 160,
  parameter int SCR_H    = 120,
  parameter int N_SPR    = 2,
  parameter int SPR_W    = 8,
  parameter int SPR_H    = 8,
  parameter int PLAYER_X = 20,
  parameter int GROUND_Y = 100,
  parameter int JUMP_V   = 6,
  parameter int GRAVITY  = 1,
  parameter int VMAX     = 8,
  parameter int TICK_DIV = 833333,
  localparam int IW      = (N_SPR > 1) ? clog2(N_SPR) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     jump,
  input  logic                     pause,
  input  logic [(N_SPR-1)*X_W-1:0] obs_x,
  output logic [X_W-1:0]           px_x,
  output logic [Y_W-1:0]           px_y,
  output logic                     plot,
  output logic [1:0]               src,
  output logic [IW-1:0]            spr_idx,
  output logic [Y_W-1:0]           player_y,
  output logic [X_W-1:0]           scroll,
  output logic                     frame_done,
  output logic                     overrun,
  output logic [2:0]               dbg_state
);

  localparam int XW1 = X_W + 1;
  localparam int YW1 = Y_W + 1;
  localparam int VW  = Y_W + 2;

  localparam logic [X_W-1:0] SCR_W_M1 = X_W'(SCR_W - 1);
  localparam logic [Y_W-1:0] SCR_H_M1 = Y_W'(SCR_H - 1);
  localparam logic [X_W-1:0] SPR_W_M1 = X_W'(SPR_W - 1);
  localparam logic [Y_W-1:0] SPR_H_M1 = Y_W'(SPR_H - 1);
  localparam logic [XW1-1:0] SCR_W_X  = XW1'(SCR_W);
  localparam logic [YW1-1:0] SCR_H_Y  = YW1'(SCR_H);
  localparam logic [Y_W-1:0] GROUND   = Y_W'(GROUND_Y);
  localparam logic [IW-1:0]  LAST_IDX = IW'(N_SPR - 1);

  state_e            state_q;
  logic [X_W-1:0]    cx_q, sx_q, ox_q, px_q, scroll_q;
  logic [Y_W-1:0]    cy_q, sy_q, oy_q, py_q, player_y_q;
  logic [IW-1:0]     sidx_q, spr_idx_q;
  logic [1:0]        src_q;
  logic              plot_q, frame_done_q, overrun_q;
  logic              jump_pend_q, tick_pend_q;
  logic signed [Y_W:0] vel_q;

  logic tick_wrap, consume;

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en_i   (state_q != IDLE),
    .wrap_o (tick_wrap)
  );

  assign consume = (state_q == WAIT_TICK) && tick_pend_q && !pause;

  // Sprite pixel coordinates carry one extra bit so off-screen pixels can be clipped.
  logic [XW1-1:0] pix_x;
  logic [YW1-1:0] pix_y;
  logic           on_screen;

  assign pix_x     = {1'b0, ox_q} + {1'b0, sx_q};
  assign pix_y     = {1'b0, oy_q} + {1'b0, sy_q};
  assign on_screen = (pix_x < SCR_W_X) && (pix_y < SCR_H_Y);

  // Origin of the sprite about to start: sprite 0 when leaving CLEAR, else the next one.
  logic [IW-1:0]  org_idx;
  logic [X_W-1:0] org_x;
  logic [Y_W-1:0] org_y;

  always_comb begin
    org_idx = (state_q == SPRITE) ? sidx_q + 1'b1 : '0;
    org_x   = X_W'(PLAYER_X);
    for (int i = 0; i < N_SPR - 1; i++) begin
      if (org_idx == IW'(i)) org_x = obs_x[i*X_W +: X_W];
    end
    org_y = (org_idx == LAST_IDX) ? player_y_q : GROUND;
  end

  // Physics: jump launch from ground, else gravity capped at VMAX, then land/ceiling clamps.
  logic signed [VW-1:0] v_sum, v_new, y_new;
  logic [Y_W-1:0]       player_y_d;
  logic signed [Y_W:0]  vel_d;

  always_comb begin
    v_sum = VW'(vel_q) + VW'(GRAVITY);
    if ((player_y_q == GROUND) && jump_pend_q) begin
      v_new = -VW'(JUMP_V);
      y_new = VW'(GROUND_Y) - VW'(JUMP_V);
    end else begin
      v_new = (v_sum > VW'(VMAX)) ? VW'(VMAX) : v_sum;
      y_new = $signed({2'b00, player_y_q}) + v_new;
    end
    if (y_new >= VW'(GROUND_Y)) begin
      player_y_d = GROUND;
      vel_d      = '0;
    end else if (y_new[VW-1]) begin
      player_y_d = '0;
      vel_d      = '0;
    end else begin
      player_y_d = y_new[Y_W-1:0];
      vel_d      = v_new[Y_W:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cx_q         <= '0;
      cy_q         <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      sidx_q       <= '0;
      ox_q         <= '0;
      oy_q         <= '0;
      px_q         <= '0;
      py_q         <= '0;
      src_q        <= SRC_BG;
      spr_idx_q    <= '0;
      plot_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      scroll_q     <= '0;
      player_y_q   <= GROUND;
      vel_q        <= '0;
      jump_pend_q  <= 1'b0;
      tick_pend_q  <= 1'b0;
    end else begin
      plot_q       <= 1'b0;
      frame_done_q <= 1'b0;
      jump_pend_q  <= jump_pend_q | jump;
      // A wrap on the consuming cycle leaves the tick pending.
      tick_pend_q  <= tick_wrap | (tick_pend_q & ~consume);
      if (tick_wrap && tick_pend_q && (state_q != WAIT_TICK)) overrun_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (start) state_q <= CLEAR;
        end

        CLEAR: begin
          plot_q    <= 1'b1;
          px_q      <= cx_q;
          py_q      <= cy_q;
          src_q     <= SRC_BG;
          spr_idx_q <= '0;
          if (cx_q == SCR_W_M1) begin
            cx_q <= '0;
            if (cy_q == SCR_H_M1) begin
              cy_q    <= '0;
              sidx_q  <= '0;
              sx_q    <= '0;
              sy_q    <= '0;
              ox_q    <= org_x;
              oy_q    <= org_y;
              state_q <= SPRITE;
            end else begin
              cy_q <= cy_q + 1'b1;
            end
          end else begin
            cx_q <= cx_q + 1'b1;
          end
        end

        SPRITE: begin
          plot_q    <= on_screen;
          px_q      <= pix_x[X_W-1:0];
          py_q      <= pix_y[Y_W-1:0];
          src_q     <= (sidx_q == LAST_IDX) ? SRC_PLAYER : SRC_OBS;
          spr_idx_q <= sidx_q;
          if (sx_q == SPR_W_M1) begin
            sx_q <= '0;
            if (sy_q == SPR_H_M1) begin
              sy_q <= '0;
              if (sidx_q == LAST_IDX) begin
                state_q <= PHYSICS;
              end else begin
                sidx_q <= sidx_q + 1'b1;
                ox_q   <= org_x;
                oy_q   <= org_y;
              end
            end else begin
              sy_q <= sy_q + 1'b1;
            end
          end else begin
            sx_q <= sx_q + 1'b1;
          end
        end

        PHYSICS: begin
          player_y_q  <= player_y_d;
          vel_q       <= vel_d;
          jump_pend_q <= 1'b0;
          state_q     <= SCROLL;
        end

        SCROLL: begin
          scroll_q     <= (scroll_q == SCR_W_M1) ? '0 : scroll_q + 1'b1;
          frame_done_q <= 1'b1;
          state_q      <= WAIT_TICK;
        end

        WAIT_TICK: begin
          if (consume) state_q <= CLEAR;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign px_x       = px_q;
  assign px_y       = py_q;
  assign plot       = plot_q;
  assign src        = src_q;
  assign spr_idx    = spr_idx_q;
  assign player_y   = player_y_q;
  assign scroll     = scroll_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer on a small 8x4 screen with 2x2 sprites.
module tb_frame_sequencer;
  import game_pkg::*;

  localparam int PW = 8 + 7 + 2 + 1;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic       reset, start, jump, pause;
  logic [7:0] obs_x;
  logic [7:0] px_x, scroll;
  logic [6:0] px_y, player_y;
  logic       plot, frame_done, overrun;
  logic [1:0] src;
  logic [0:0] spr_idx;
  logic [2:0] dbg_state;

  logic       reset2, start2;
  logic [7:0] px_x2, scroll2;
  logic [6:0] px_y2, player_y2;
  logic       plot2, frame_done2, overrun2;
  logic [1:0] src2;
  logic [0:0] spr_idx2;
  logic [2:0] dbg_state2;
  logic       done2 = 1'b0;

  frame_sequencer #(
    .X_W(8), .Y_W(7), .SCR_W(8), .SCR_H(4), .N_SPR(2), .SPR_W(2), .SPR_H(2),
    .PLAYER_X(1), .GROUND_Y(2), .JUMP_V(2), .GRAVITY(1), .VMAX(3), .TICK_DIV(100)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .jump(jump), .pause(pause),
    .obs_x(obs_x), .px_x(px_x), .px_y(px_y), .plot(plot), .src(src),
    .spr_idx(spr_idx), .player_y(player_y), .scroll(scroll),
    .frame_done(frame_done), .overrun(overrun), .dbg_state(dbg_state)
  );

  frame_sequencer #(
    .X_W(8), .Y_W(7), .SCR_W(8), .SCR_H(4), .N_SPR(2), .SPR_W(2), .SPR_H(2),
    .PLAYER_X(1), .GROUND_Y(2), .JUMP_V(2), .GRAVITY(1), .VMAX(3), .TICK_DIV(30)
  ) dut_fast (
    .clk(clk), .reset(reset2), .start(start2), .jump(1'b0), .pause(1'b0),
    .obs_x(8'd0), .px_x(px_x2), .px_y(px_y2), .plot(plot2), .src(src2),
    .spr_idx(spr_idx2), .player_y(player_y2), .scroll(scroll2),
    .frame_done(frame_done2), .overrun(overrun2), .dbg_state(dbg_state2)
  );

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];
  logic [14:0]   fexp_q[$];
  int frames_seen = 0;
  int clear_entry = 0;
  logic [2:0] prev_st = 3'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_pix(input int x, input int y, input int s, input int idx);
    exp_q.push_back({8'(x), 7'(y), 2'(s), 1'(idx)});
  endtask

  // Expected pixels of one frame: 8x4 raster, obstacle at (ox,2), player at (1,pyd).
  task automatic push_frame(input int ox, input int pyd, input int scr, input int pya);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) push_pix(x, y, 0, 0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        if (ox + c < 8 && 2 + r < 4) push_pix(ox + c, 2 + r, 1, 0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        if (1 + c < 8 && pyd + r < 4) push_pix(1 + c, pyd + r, 2, 1);
    fexp_q.push_back({8'(scr), 7'(pya)});
  endtask

  // Monitors
  always @(negedge clk) begin : plot_mon
    logic [PW-1:0] e;
    if (plot) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d src=%0d, required no plot", px_x, px_y, src);
      end else begin
        e = exp_q.pop_front();
        chk("pixel{x,y,src,idx}", 32'({px_x, px_y, src, spr_idx}), 32'(e));
      end
    end
  end

  always @(negedge clk) begin : state_mon
    if (dbg_state == CLEAR && prev_st != CLEAR) clear_entry = cyc;
    prev_st = dbg_state;
  end

  always @(negedge clk) begin : frame_mon
    logic [14:0] fe;
    if (frame_done) begin
      chk("frame_len", 32'(cyc - clear_entry), 32'd42);
      chk("plots_drained", 32'(exp_q.size()), 32'd0);
      if (fexp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_done at cycle %0d, required none", cyc);
      end else begin
        fe = fexp_q.pop_front();
        chk("scroll", 32'(scroll), 32'(fe[14:7]));
        chk("player_y", 32'(player_y), 32'(fe[6:0]));
      end
      frames_seen++;
    end
  end

  // Driver tasks
  task automatic wait_frames(input int n);
    int k = 0;
    while (frames_seen < n && k < 600) begin
      @(negedge clk);
      k++;
    end
    if (frames_seen < n) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got %0d frames, required %0d", frames_seen, n);
    end
  endtask

  task automatic wait_state(input logic [2:0] s);
    int k = 0;
    while (dbg_state != s && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (dbg_state != s) begin
      checks++;
      errors++;
      $display("FAIL state_timeout: got %0d, required %0d", dbg_state, s);
    end
  endtask

  // Short tick period: frames run back-to-back and overrun latches.
  initial begin : fast_seq
    int n, k, last, intv, n_more;
    reset2 = 1'b1;
    start2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("fast_overrun_reset", 32'(overrun2), 32'd0);
    reset2 = 1'b0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0; k = 0; last = 0; intv = 0;
    while (n < 6 && k < 2000) begin
      @(negedge clk);
      k++;
      if (frame_done2) begin
        n++;
        intv = cyc - last;
        last = cyc;
      end
    end
    chk("fast_frames", 32'(n), 32'd6);
    chk("fast_overrun_set", 32'(overrun2), 32'd1);
    chk("fast_frame_period", 32'(intv), 32'd43);
    n_more = 0;
    repeat (100) begin
      @(negedge clk);
      if (frame_done2) n_more++;
    end
    chk("fast_frames_continue", 32'(n_more >= 2), 32'd1);
    chk("fast_overrun_sticky", 32'(overrun2), 32'd1);
    done2 = 1'b1;
  end

  int pyd_t[9] = '{2, 2, 2, 0, 0, 1, 2, 2, 2};
  int pya_t[9] = '{2, 2, 0, 0, 1, 2, 2, 2, 0};

  initial begin : main_seq
    int ox, k;
    reset = 1'b1;
    start = 1'b0;
    jump  = 1'b0;
    pause = 1'b0;
    obs_x = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_scroll", 32'(scroll), 32'd0);
    chk("rst_px", 32'({px_x, px_y}), 32'd0);
    chk("rst_src_idx", 32'({src, spr_idx}), 32'd0);
    chk("rst_player_y", 32'(player_y), 32'd2);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_without_start", 32'(dbg_state), 32'(IDLE));

    // Frames 1..9: obstacle clipping, jump arc with ceiling clamp, scroll wrap.
    for (int f = 1; f <= 9; f++) begin
      ox = (f == 1) ? 3 : (f == 2) ? 7 : 5;
      obs_x = 8'(ox);
      push_frame(ox, pyd_t[f-1], f % 8, pya_t[f-1]);
      if (f == 1) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      if (f == 3 || f == 9) begin
        wait_state(CLEAR);
        repeat (3) @(negedge clk);
        jump = 1'b1;
        @(negedge clk);
        jump = 1'b0;
      end
      wait_frames(f);
    end
    chk("main_no_overrun", 32'(overrun), 32'd0);

    // Frame 10: reset part-way through sprite drawing.
    obs_x = 8'd5;
    push_frame(5, 0, 2, 1);
    wait_state(SPRITE);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    fexp_q.delete();
    @(negedge clk);
    chk("midrst_plot", 32'(plot), 32'd0);
    chk("midrst_player_y", 32'(player_y), 32'd2);
    chk("midrst_scroll", 32'(scroll), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_after_reset", 32'(dbg_state), 32'(IDLE));

    k = 0;
    while (!done2 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (!done2) begin
      checks++;
      errors++;
      $display("FAIL fast_seq_timeout: got not done, required done");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
